// File: rtl/detector_presencia.sv
// Debounced presence detector with short-visit ("caricia") event generation.
// Optional caricia counter built only when DETECTOR_PRESENCIA_CONTADOR_EN is defined.
module detector_presencia #(
  parameter int unsigned W            = 9,
  parameter int unsigned UMBRAL_CERCA = 20,
  parameter int unsigned UMBRAL_LEJOS = 30,
  parameter int unsigned N_CONFIRM    = 3,
  parameter int unsigned CARICIA_MAX  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] dist_cm,
  input  logic         dist_valid,
  input  logic         dist_timeout,
  output logic         presente,
  output logic         caricia,
  output logic [7:0]   caricias_cnt,
  output logic [1:0]   estado
);

  typedef enum logic [1:0] {
    LEJOS     = 2'd0,
    ACERCANDO = 2'd1,
    CERCA     = 2'd2,
    ALEJANDO  = 2'd3
  } state_e;

  localparam logic [3:0] NCONF   = 4'(N_CONFIRM);
  localparam logic [5:0] DUR_MAX = 6'(CARICIA_MAX);
  localparam logic [5:0] DUR_SAT = 6'(CARICIA_MAX + 1);

  state_e     state_q, state_d;
  logic [3:0] conf_q, conf_d;
  logic [5:0] dur_q, dur_d;
  logic       presente_q, presente_d;
  logic       caricia_q, caricia_d;

  logic       far_s, near_s;
  logic [3:0] conf_inc;
  logic [5:0] dur_inc;
  logic       exit_visit;

  // Timeout wins over a simultaneous valid; a zero distance is a glitch (neutral).
  assign far_s  = dist_timeout || (dist_valid && (dist_cm >= W'(UMBRAL_LEJOS)));
  assign near_s = !dist_timeout && dist_valid && (dist_cm != '0) &&
                  (dist_cm <= W'(UMBRAL_CERCA));

  assign conf_inc = conf_q + 4'd1;
  assign dur_inc  = (dur_q >= DUR_SAT) ? dur_q : dur_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    conf_d     = conf_q;
    dur_d      = dur_q;
    presente_d = presente_q;
    caricia_d  = 1'b0;
    exit_visit = 1'b0;
    unique case (state_q)
      LEJOS: begin
        if (near_s) begin
          if (N_CONFIRM == 1) begin
            state_d    = CERCA;
            presente_d = 1'b1;
            dur_d      = '0;
            conf_d     = '0;
          end else begin
            state_d = ACERCANDO;
            conf_d  = 4'd1;
          end
        end
      end
      ACERCANDO: begin
        if (near_s) begin
          if (conf_inc >= NCONF) begin
            state_d    = CERCA;
            presente_d = 1'b1;
            dur_d      = '0;
            conf_d     = '0;
          end else begin
            conf_d = conf_inc;
          end
        end else if (far_s) begin
          state_d = LEJOS;
          conf_d  = '0;
        end
      end
      CERCA: begin
        if (near_s || far_s) dur_d = dur_inc;
        if (far_s) begin
          if (N_CONFIRM == 1) begin
            exit_visit = 1'b1;
          end else begin
            state_d = ALEJANDO;
            conf_d  = 4'd1;
          end
        end
      end
      ALEJANDO: begin
        if (near_s || far_s) dur_d = dur_inc;
        if (far_s) begin
          if (conf_inc >= NCONF) exit_visit = 1'b1;
          else conf_d = conf_inc;
        end else if (near_s) begin
          state_d = CERCA;
          conf_d  = '0;
        end
      end
      default: state_d = LEJOS;
    endcase
    // Visit length judged on the count including the sample that ends the visit.
    if (exit_visit) begin
      state_d    = LEJOS;
      presente_d = 1'b0;
      conf_d     = '0;
      caricia_d  = (dur_inc <= DUR_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LEJOS;
      conf_q     <= '0;
      dur_q      <= '0;
      presente_q <= 1'b0;
      caricia_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      conf_q     <= conf_d;
      dur_q      <= dur_d;
      presente_q <= presente_d;
      caricia_q  <= caricia_d;
    end
  end

`ifdef DETECTOR_PRESENCIA_CONTADOR_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (caricia_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign caricias_cnt = cnt_q;
`else
  assign caricias_cnt = '0;
`endif

  assign presente = presente_q;
  assign caricia  = caricia_q;
  assign estado   = 2'(state_q);

endmodule

// File: tb/tb_detector_presencia.sv
// Scoreboard bench for detector_presencia: stimulus pushes expected post-strobe
// outputs, a negedge monitor pops and compares after every consumed strobe.
module tb_detector_presencia;

`ifdef DETECTOR_PRESENCIA_CONTADOR_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [1:0] S_LEJOS = 2'd0, S_ACER = 2'd1, S_CERCA = 2'd2, S_ALEJ = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       dist_timeout;
  logic       presente;
  logic       caricia;
  logic [7:0] caricias_cnt;
  logic [1:0] estado;

  typedef struct packed {
    logic [1:0] est;
    logic       pres;
    logic       car;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;
  logic s_q     = 1'b0;

  detector_presencia dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dist_cm      (dist_cm),
    .dist_valid   (dist_valid),
    .dist_timeout (dist_timeout),
    .presente     (presente),
    .caricia      (caricia),
    .caricias_cnt (caricias_cnt),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
  endtask

  // Remember whether the edge just taken consumed a strobe.
  always @(posedge clk) s_q <= rst_n && (dist_valid || dist_timeout);

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_q) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("estado", int'(estado), int'(e.est));
          check("presente", int'(presente), int'(e.pres));
          check("caricia", int'(caricia), int'(e.car));
          check("caricias_cnt", int'(caricias_cnt), int'(e.cnt));
        end
      end else begin
        check("caricia_idle", int'(caricia), 0);
      end
    end
  end

  // Drives one strobe cycle (called at posedge+1) and records its expected outcome.
  task automatic send(input logic v, input logic t, input logic [8:0] d,
                      input logic [1:0] est, input logic pres, input logic car);
    exp_t x;
    if (car && CNT_EN && exp_cnt < 255) exp_cnt++;
    x.est  = est;
    x.pres = pres;
    x.car  = car;
    x.cnt  = 8'(exp_cnt);
    sb.push_back(x);
    dist_valid   = v;
    dist_timeout = t;
    dist_cm      = d;
    @(posedge clk);
    #1;
    dist_valid   = 1'b0;
    dist_timeout = 1'b0;
    dist_cm      = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dist_valid = 1'b0; dist_timeout = 1'b0; dist_cm = '0;
    @(posedge clk);
    #1;
    // Reset held with random strobes: outputs stay cleared.
    for (int i = 0; i < 8; i++) begin
      dist_valid   = 1'($urandom_range(1));
      dist_timeout = 1'($urandom_range(1));
      dist_cm      = 9'($urandom_range(40));
      @(negedge clk);
      check("rst_presente", int'(presente), 0);
      check("rst_caricia", int'(caricia), 0);
      check("rst_cnt", int'(caricias_cnt), 0);
      check("rst_estado", int'(estado), 0);
      @(posedge clk);
      #1;
    end
    dist_valid = 1'b0; dist_timeout = 1'b0; dist_cm = '0;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_estado", int'(estado), 0);
    send(1, 0, 9'd50, S_LEJOS, 0, 0);
    send(0, 1, 9'd0,  S_LEJOS, 0, 0);

    // Confirmed short visit.
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 0, 9'd50, S_ALEJ,  1, 0);
    send(1, 0, 9'd50, S_ALEJ,  1, 0);
    send(1, 0, 9'd50, S_LEJOS, 0, 1);
    idle(3);

    // Hysteresis band and zero-distance glitches are neutral.
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd25, S_ACER,  0, 0);
    send(1, 0, 9'd0,  S_ACER,  0, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 0, 9'd0,  S_CERCA, 1, 0);
    send(1, 0, 9'd50, S_ALEJ,  1, 0);
    send(1, 0, 9'd29, S_ALEJ,  1, 0);
    send(1, 0, 9'd50, S_ALEJ,  1, 0);
    send(1, 0, 9'd30, S_LEJOS, 0, 1);
    idle(1);

    // Interrupted approach never confirms.
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd50, S_LEJOS, 0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd20, S_ACER,  0, 0);
    send(1, 0, 9'd50, S_LEJOS, 0, 0);

    // Long visit: dur saturates, no caricia on exit.
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    for (int i = 0; i < 12; i++) send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(0, 1, 9'd0, S_ALEJ,  1, 0);
    send(0, 1, 9'd0, S_ALEJ,  1, 0);
    send(0, 1, 9'd0, S_LEJOS, 0, 0);
    idle(2);

    // Timeout wins over a simultaneous near measurement; NEAR in ALEJANDO returns to CERCA.
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 1, 9'd10, S_ALEJ,  1, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(1, 1, 9'd10, S_ALEJ,  1, 0);
    send(1, 1, 9'd10, S_ALEJ,  1, 0);
    idle(2);

    // Asynchronous reset in ALEJANDO: immediate LEJOS, no caricia.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_estado", int'(estado), 0);
    check("arst_presente", int'(presente), 0);
    check("arst_cnt", int'(caricias_cnt), 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("arst_caricia", int'(caricia), 0);
    rst_n = 1'b1;
    idle(1);
    send(0, 1, 9'd0,  S_LEJOS, 0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_ACER,  0, 0);
    send(1, 0, 9'd15, S_CERCA, 1, 0);
    send(0, 1, 9'd0,  S_ALEJ,  1, 0);
    send(0, 1, 9'd0,  S_ALEJ,  1, 0);
    send(0, 1, 9'd0,  S_LEJOS, 0, 1);

    // Many back-to-back short visits: counter saturates (or stays 0 without the counter).
    for (int i = 0; i < 260; i++) begin
      send(1, 0, 9'd15, S_ACER,  0, 0);
      send(1, 0, 9'd15, S_ACER,  0, 0);
      send(1, 0, 9'd15, S_CERCA, 1, 0);
      send(1, 0, 9'd50, S_ALEJ,  1, 0);
      send(1, 0, 9'd50, S_ALEJ,  1, 0);
      send(1, 0, 9'd50, S_LEJOS, 0, 1);
    end
    idle(2);
    check("final_cnt", int'(caricias_cnt), CNT_EN ? 255 : 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
